serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serial frame transmitter: accepts parallel words over a valid/ready handshake and drives them onto a single-bit serial line as framed bit sequences (start bit, data LSB-first, optional parity, stop bit), each bit held for a fixed number of clocks. It produces the serial bitstream that the team's serial-line detector state machines consume, and serves as their stimulus source and link partner.

## Interface
- DATA_W, default 8: data bits per frame; legal range 1–16.
- CLKS_PER_BIT, default 4: clocks each serial bit is held; legal range 1–256.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_W  word to send; sampled only on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  transmitter can accept a word this cycle.
- ser_out  output  1  serial line; idle level 0.
- busy  output  1  frame in progress (any state except IDLE).
- frame_done  output  1  one-cycle pulse in the final clock of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (exists only with the macro enabled), STOP.
- Accept: tx_valid && tx_ready at a rising edge. tx_data is copied into a DATA_W shift register; later changes to tx_data are ignored.
- tx_ready = (state == IDLE) || (state == STOP && last clock of bit). It is combinational from state and counters and does not depend on tx_valid.
- Line levels by state:
  - IDLE: ser_out = 0.
  - START: ser_out = 1.
  - DATA: ser_out = shreg[0], sent LSB first; shift right at each bit boundary.
  - PARITY: ser_out = even parity, i.e. XOR of the accepted word.
  - STOP: ser_out = 0.
- Bit counter: 0..DATA_W-1, counted within DATA only. Clock counter: 0..CLKS_PER_BIT-1 within every non-IDLE bit.
- Transitions, at the last clock of each bit:
  - START → DATA.
  - DATA (bit DATA_W-1) → PARITY if enabled, else → STOP.
  - PARITY → STOP.
  - STOP → START if an accept occurs that cycle, else → IDLE.
  - IDLE → START on accept.
- In IDLE, tx_valid = 0 has no effect.

## Timing
- Reset values: state IDLE, ser_out 0, tx_ready 1, busy 0, frame_done 0, all counters 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously). Line returns to 0 and the word is lost.
- Latency: an accept at edge N makes ser_out = 1 (start bit) from edge N onward.
- Frame length: (DATA_W + 2 [+1 with parity]) × CLKS_PER_BIT clocks.
- Back-to-back: an accept in the last STOP clock gives a start bit at the very next clock, with no idle gap. Stream rate is exactly one frame per frame length.
- CLKS_PER_BIT = 1: every state lasts one clock, and all rules above still hold.
- Simultaneous accept and frame_done in the last STOP clock: both occur.

## Configuration
- SERIAL_FRAME_TX_PARITY_EN:
  - Defined: PARITY state is compiled in, inserted between DATA and STOP, and carries even parity. Frame length includes +1 bit.
  - Undefined: PARITY state and parity logic are absent, and DATA goes directly to STOP.

## Structure
- Package serial_frame_pkg holds:
  - State enum type tx_state_t.
  - Constants START_LVL = 1, STOP_LVL = 0, IDLE_LVL = 0.
  - Function for even parity of a word.
- Sub-module bit_timer holds the clock counter. It takes clk, reset, run and load, and outputs bit_last, asserted in the last clock of each bit. It is parameterized by CLKS_PER_BIT.
- The FSM, bit counter and shift register live in serial_frame_tx.

## Test plan
All scenarios use DATA_W = 8 and CLKS_PER_BIT = 4.
- Reset with tx_valid = 0 for 20 clocks → ser_out = 0, tx_ready = 1, busy = 0 throughout.
- Send 0xA5, parity disabled → ser_out per bit 1,1,0,1,0,0,1,0,1,0, each held 4 clocks; 40 clocks total; frame_done pulses once at clock 40; tx_ready low during clocks 1–39.
- Parity enabled, send 0xA5 then 0x07 → parity bits 0 and 1 respectively; each frame is 44 clocks.
- tx_valid held high with words 0x01, 0x02, 0x03 → three contiguous frames with no idle clock between them; each accept coincides with frame_done.
- Reset asserted at clock 13 of a 0xFF frame → ser_out = 0 immediately; after release, a new 0x3C frame is transmitted correctly.
- tx_data changed from 0x55 to 0xAA the cycle after accept → line carries 0x55.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types, line levels and parity helper for the serial frame transmitter.
// SERIAL_FRAME_TX_PARITY_EN adds the PARITY state to the state enum.
package serial_frame_pkg;

    localparam int unsigned MAX_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit clock counter; bit_last marks the final clock of every serial bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic load,
    output logic bit_last
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_last = run && (cnt_q == LAST);

    // Restart on a new frame, while idle, and at each bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load || !run || bit_last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    import serial_frame_pkg::*;

    localparam int unsigned BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              bit_last;
    logic              accept;
    logic              run;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic par_q, par_d;
`endif

    assign run        = (state_q != IDLE);
    assign tx_ready   = (state_q == IDLE) || ((state_q == STOP) && bit_last);
    assign accept     = tx_valid && tx_ready;
    assign busy       = run;
    assign frame_done = (state_q == STOP) && bit_last;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .load    (accept),
        .bit_last(bit_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    // Parity is captured at accept since the shift register is consumed by DATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Next-state, bit counter and shift register update.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d     = par_q;
        if (accept) begin
            par_d = even_parity(MAX_DATA_W'(tx_data));
        end
`endif
        if (accept) begin
            state_d   = START;
            bit_cnt_d = '0;
            shreg_d   = tx_data;
        end else begin
            case (state_q)
                START: begin
                    if (bit_last) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        shreg_d = shreg_q >> 1;
                        if (bit_cnt_q == BCNT_LAST) begin
                            bit_cnt_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PARITY: begin
                    if (bit_last) begin
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Line level is a pure decode of registered state.
    always_comb begin
        ser_out = IDLE_LVL;
        case (state_q)
            START:   ser_out = START_LVL;
            DATA:    ser_out = shreg_q[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY:  ser_out = par_q;
`endif
            STOP:    ser_out = STOP_LVL;
            default: ser_out = IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed and random frames checked against a frame-level reference.
module tb_serial_frame_tx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = DATA_W + 2 + PAR_BITS;
    localparam int FL    = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ser_out;
    logic       busy;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    serial_frame_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ser_out   (ser_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end

    // Frame bit idx of word w: 0 start, 1..DATA_W data LSB first, then parity, then stop.
    function automatic logic exp_bit(input logic [7:0] w, input int idx);
        logic [7:0] t;
        if (idx == 0) return 1'b1;
        if (idx <= DATA_W) begin
            t = w >> (idx - 1);
            return t[0];
        end
        if (PAR_BITS == 1 && idx == DATA_W + 1) return ^w;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle ser_out", ser_out, 1'b0);
        check("idle busy", busy, 1'b0);
        check("idle tx_ready", tx_ready, 1'b1);
        check("idle frame_done", frame_done, 1'b0);
    endtask

    // Called at a negedge with the accept for w already driven; ends at the negedge of the last clock.
    task automatic run_frame(input logic [7:0] w, input bit chain, input logic [7:0] nw);
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= FL; k++) begin
            if (k == 1) tx_data = ~w;
            else        tx_data = 8'($urandom);
            if (k < FL) begin
                tx_valid = 1'($urandom % 2);
            end else begin
                tx_valid = chain;
                if (chain) tx_data = nw;
            end
            check($sformatf("ser_out w=%02h clk=%0d", w, k), ser_out, exp_bit(w, (k - 1) / CPB));
            check($sformatf("busy w=%02h clk=%0d", w, k), busy, 1'b1);
            check($sformatf("tx_ready w=%02h clk=%0d", w, k), tx_ready, k == FL);
            check($sformatf("frame_done w=%02h clk=%0d", w, k), frame_done, k == FL);
            if (k < FL) @(negedge clk);
        end
    endtask

    task automatic single(input logic [7:0] w);
        tx_valid = 1'b1;
        tx_data  = w;
        check("ready before accept", tx_ready, 1'b1);
        run_frame(w, 1'b0, 8'h00);
        idle_check();
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;
        bit         ch;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1;
        check("reset ser_out", ser_out, 1'b0);
        check("reset tx_ready", tx_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) idle_check();

        single(8'hA5);
        single(8'h07);

        // tx_valid held through three contiguous frames
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        run_frame(8'h01, 1'b1, 8'h02);
        run_frame(8'h02, 1'b1, 8'h03);
        run_frame(8'h03, 1'b0, 8'h00);
        idle_check();

        // Reset during clock 13 of a 0xFF frame
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("pre-abort ser_out clk=%0d", k), ser_out, exp_bit(8'hFF, (k - 1) / CPB));
            if (k < 13) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("abort ser_out", ser_out, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort tx_ready", tx_ready, 1'b1);
        check("abort frame_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_check();
        single(8'h3C);

        // Data changes to 0xAA the cycle after accept
        single(8'h55);

        // Random words with random chaining and idle gaps
        cur      = 8'($urandom);
        tx_valid = 1'b1;
        tx_data  = cur;
        for (int i = 0; i < 12; i++) begin
            nxt = 8'($urandom);
            ch  = (i != 11) && ($urandom_range(0, 1) == 1);
            run_frame(cur, ch, nxt);
            if (!ch) begin
                repeat ($urandom_range(1, 3)) idle_check();
                if (i != 11) begin
                    tx_valid = 1'b1;
                    tx_data  = nxt;
                end
            end
            cur = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
